// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the direct-mapped write-back data cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH
  } state_t;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  // Tags are held right-aligned in a field wide enough for any supported address width.
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU request and dataMemory signals for dcache_ctrl; slave = cache side, master = CPU/memory side.
interface dcache_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_fetch;
  logic                  mem_writeback;
  logic [DATA_WIDTH-1:0] mem_wb_data;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req, we, addr, wdata, funct3, mem_rdata,
    output rdata, stall, mem_addr, mem_fetch, mem_writeback, mem_wb_data
  );

  modport master (
    output req, we, addr, wdata, funct3, mem_rdata,
    input  rdata, stall, mem_addr, mem_fetch, mem_writeback, mem_wb_data
  );
endinterface

// File: rtl/dcache_ctrl_store_merge.sv
// Byte/halfword/word store merge into an existing cache word (combinational).
module store_merge
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_offset,
  output logic [DATA_WIDTH-1:0] o_merged
);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    o_merged = i_old;
    case (i_funct3)
      FUNCT3_SB: o_merged[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
      FUNCT3_SH: o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      FUNCT3_SW: o_merged = i_wdata;
      default:   o_merged = i_old;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with one-word lines.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SETS        = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  dcache_ctrl_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = DATA_WIDTH - INDEX_W - 2;
  localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [SETS-1:0]       r_valid;
  logic [SETS-1:0]       r_dirty;
  logic [TAG_W-1:0]      r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS];

  logic [INDEX_W-1:0]    w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [1:0]            w_offset;
  line_meta_t            w_meta;
  logic                  w_hit;
  logic                  w_store_hit;
  logic                  w_last;
  logic                  w_miss_start;
  logic [DATA_WIDTH-1:0] w_line;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_offset = bus.addr[1:0];
  assign w_index  = bus.addr[INDEX_W+1:2];
  assign w_tag    = bus.addr[DATA_WIDTH-1:INDEX_W+2];
  assign w_line   = r_data[w_index];

  assign w_meta = '{valid: r_valid[w_index],
                    dirty: r_dirty[w_index],
                    tag:   TAG_MAX_W'(r_tag[w_index])};

  assign w_hit       = (r_state == IDLE) && bus.req && w_meta.valid &&
                       (w_meta.tag == TAG_MAX_W'(w_tag));
  assign w_store_hit = w_hit && bus.we;
  assign w_last      = (r_cnt == CNT_W'(MEM_LATENCY - 1));

  store_merge #(.DATA_WIDTH(DATA_WIDTH)) u_store_merge (
    .i_old    (w_line),
    .i_wdata  (bus.wdata),
    .i_funct3 (bus.funct3),
    .i_offset (w_offset),
    .o_merged (w_merged)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_miss_start      = 1'b0;
    bus.stall         = 1'b0;
    bus.rdata         = '0;
    bus.mem_addr      = '0;
    bus.mem_fetch     = 1'b0;
    bus.mem_writeback = 1'b0;
    bus.mem_wb_data   = '0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          if (!bus.we) bus.rdata = w_line;
        end else if (bus.req) begin
          bus.stall    = 1'b1;
          w_miss_start = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = (w_meta.valid && w_meta.dirty) ? WB : FETCH;
        end
      end
      WB: begin
        bus.stall         = 1'b1;
        bus.mem_writeback = (r_cnt == '0);
        bus.mem_addr      = {2'b00, r_tag[w_index], w_index};
        bus.mem_wb_data   = w_line;
        w_cnt_nxt         = w_last ? '0 : r_cnt + 1'b1;
        if (w_last) w_state_nxt = FETCH;
      end
      FETCH: begin
        bus.stall     = 1'b1;
        bus.mem_fetch = 1'b1;
        bus.mem_addr  = {2'b00, bus.addr[DATA_WIDTH-1:2]};
        w_cnt_nxt     = w_last ? '0 : r_cnt + 1'b1;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (r_state == WB && w_last) r_dirty[w_index] <= 1'b0;
      if (r_state == FETCH && w_last) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
      if (w_store_hit) r_dirty[w_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (r_state == FETCH && w_last) begin
      r_data[w_index] <= bus.mem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_store_hit) begin
      r_data[w_index] <= w_merged;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit)        r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss_start) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl (SETS=64, MEM_LATENCY=2).
module tb_dcache_ctrl;
  import cache_pkg::*;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  int          tests_run;
  int          tests_failed;
  int          exp_hits;
  int          exp_misses;

  dcache_ctrl_if #(.DATA_WIDTH(32)) bus ();

  dcache_ctrl #(.DATA_WIDTH(32), .SETS(64), .MEM_LATENCY(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Fixed-content memory: word 0x4000 holds 0x1122_3344, others read 0xCAFE_<addr[15:0]>.
  assign bus.mem_rdata = (bus.mem_addr == 32'h0000_4000) ? 32'h1122_3344
                                                         : {16'hCAFE, bus.mem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request just after a rising edge; return sampling 2 time units after that edge.
  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
    @(posedge clk);
    #1;
    bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; bus.funct3 = f3;
    #1;
  endtask

  // Step through a miss sequence, recording what the cache showed to memory.
  task automatic wait_miss(input logic [31:0] fetch_addr, output int stalls, output int fetches,
                           output int wbs, output int bad_addr, output bit timed_out,
                           output logic [31:0] wb_addr, output logic [31:0] wb_data);
    stalls = 0; fetches = 0; wbs = 0; bad_addr = 0; wb_addr = '0; wb_data = '0;
    while (bus.stall === 1'b1 && stalls < 50) begin
      stalls++;
      if (bus.mem_fetch === 1'b1) begin
        fetches++;
        if (bus.mem_addr !== fetch_addr) bad_addr++;
      end
      if (bus.mem_writeback === 1'b1) begin
        wbs++;
        wb_addr = bus.mem_addr;
        wb_data = bus.mem_wb_data;
      end
      @(posedge clk);
      #2;
    end
    timed_out = (stalls >= 50);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.funct3 = FUNCT3_SW;
    #12;
    tests_run++;
    if ({bus.stall, bus.mem_fetch, bus.mem_writeback} !== 3'b000 || bus.mem_addr !== 32'h0 ||
        bus.mem_wb_data !== 32'h0 || bus.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got stall=%b fetch=%b wb=%b maddr=%h wbdata=%h rdata=%h want all 0",
               bus.stall, bus.mem_fetch, bus.mem_writeback, bus.mem_addr, bus.mem_wb_data, bus.rdata);
    end
    tests_run++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load_miss();
    int s, f, w, bad;
    bit to;
    logic [31:0] wa, wd;
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0, FUNCT3_SW);
    wait_miss(32'h0000_4000, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 3 || f != 2 || w != 0 || bad != 0) begin
      tests_failed++;
      $display("FAIL load_miss_seq: got stall=%0d fetch=%0d wb=%0d badaddr=%0d timeout=%0b want 3 2 0 0 0",
               s, f, w, bad, to);
    end
    tests_run++;
    if (bus.rdata !== 32'h1122_3344) begin
      tests_failed++;
      $display("FAIL load_miss_rdata: got %h want 11223344", bus.rdata);
    end
  endtask

  task automatic test_load_hit();
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0, FUNCT3_SW);
    if (STATS) exp_hits++;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.rdata !== 32'h1122_3344) begin
      tests_failed++;
      $display("FAIL load_hit: got stall=%b rdata=%h want 0 11223344", bus.stall, bus.rdata);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, FUNCT3_SW);
    tests_run++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      tests_failed++;
      $display("FAIL load_hit_counters: got hit=%0d miss=%0d want %0d %0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  // Back-to-back store/load hits exercising each store size and an unsupported funct3.
  task automatic test_store_merge();
    logic [31:0] a [4];
    logic [31:0] d [4];
    logic [2:0]  f [4];
    logic [31:0] e [4];
    a = '{32'h0001_0002, 32'h0001_0000, 32'h0001_0001, 32'h0001_0003};
    d = '{32'h0000_00AB, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h1234_5678};
    f = '{FUNCT3_SB,     FUNCT3_SH,     3'b011,        FUNCT3_SB};
    e = '{32'h11AB_3344, 32'h11AB_BEEF, 32'h11AB_BEEF, 32'h78AB_BEEF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, a[i], d[i], f[i]);
      if (STATS) exp_hits++;
      tests_run++;
      if (bus.stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL store_hit_stall[%0d]: got %b want 0", i, bus.stall);
      end
      drive(1'b1, 1'b0, 32'h0001_0000, 32'h0, FUNCT3_SW);
      if (STATS) exp_hits++;
      tests_run++;
      if (bus.rdata !== e[i]) begin
        tests_failed++;
        $display("FAIL store_merge[%0d]: got %h want %h", i, bus.rdata, e[i]);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, FUNCT3_SW);
  endtask

  task automatic test_dirty_evict();
    int s, f, w, bad;
    bit to;
    logic [31:0] wa, wd;
    drive(1'b1, 1'b0, 32'h0001_0100, 32'h0, FUNCT3_SW);
    wait_miss(32'h0000_4040, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 5 || f != 2 || w != 1 || bad != 0) begin
      tests_failed++;
      $display("FAIL evict_seq: got stall=%0d fetch=%0d wb=%0d badaddr=%0d timeout=%0b want 5 2 1 0 0",
               s, f, w, bad, to);
    end
    tests_run++;
    if (wa !== 32'h0000_4000 || wd !== 32'h78AB_BEEF) begin
      tests_failed++;
      $display("FAIL evict_victim: got addr=%h data=%h want 00004000 78abbeef", wa, wd);
    end
    tests_run++;
    if (bus.rdata !== 32'hCAFE_4040) begin
      tests_failed++;
      $display("FAIL evict_rdata: got %h want cafe4040", bus.rdata);
    end
    // The refilled line is clean, so evicting it needs no writeback.
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0, FUNCT3_SW);
    wait_miss(32'h0000_4000, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 3 || w != 0 || bus.rdata !== 32'h1122_3344) begin
      tests_failed++;
      $display("FAIL clean_evict: got stall=%0d wb=%0d rdata=%h want 3 0 11223344", s, w, bus.rdata);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, FUNCT3_SW);
  endtask

  task automatic test_store_miss();
    int s, f, w, bad;
    bit to;
    logic [31:0] wa, wd;
    drive(1'b1, 1'b1, 32'h0003_0008, 32'h5A5A_5A5A, FUNCT3_SW);
    wait_miss(32'h0000_C002, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 3 || f != 2 || w != 0 || bad != 0) begin
      tests_failed++;
      $display("FAIL store_miss_seq: got stall=%0d fetch=%0d wb=%0d badaddr=%0d want 3 2 0 0", s, f, w, bad);
    end
    drive(1'b1, 1'b0, 32'h0003_0008, 32'h0, FUNCT3_SW);
    if (STATS) exp_hits++;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.rdata !== 32'h5A5A_5A5A) begin
      tests_failed++;
      $display("FAIL store_miss_data: got stall=%b rdata=%h want 0 5a5a5a5a", bus.stall, bus.rdata);
    end
    drive(1'b1, 1'b0, 32'h0003_0108, 32'h0, FUNCT3_SW);
    wait_miss(32'h0000_C042, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 5 || w != 1 || wa !== 32'h0000_C002 || wd !== 32'h5A5A_5A5A ||
        bus.rdata !== 32'hCAFE_C042) begin
      tests_failed++;
      $display("FAIL store_miss_evict: got stall=%0d wb=%0d addr=%h data=%h rdata=%h want 5 1 0000c002 5a5a5a5a cafec042",
               s, w, wa, wd, bus.rdata);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, FUNCT3_SW);
  endtask

  task automatic test_reset_mid_fetch();
    int s, f, w, bad;
    bit to;
    logic [31:0] wa, wd;
    drive(1'b1, 1'b0, 32'h0002_0004, 32'h0, FUNCT3_SW);
    @(posedge clk);
    #2;
    tests_run++;
    if (bus.mem_fetch !== 1'b1 || bus.mem_addr !== 32'h0000_8001) begin
      tests_failed++;
      $display("FAIL mid_fetch_active: got fetch=%b addr=%h want 1 00008001", bus.mem_fetch, bus.mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    tests_run++;
    if (bus.mem_fetch !== 1'b0 || bus.mem_writeback !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wb_data !== 32'h0 || bus.rdata !== 32'h0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got fetch=%b wb=%b addr=%h wbdata=%h rdata=%h hit=%0d miss=%0d want all 0",
               bus.mem_fetch, bus.mem_writeback, bus.mem_addr, bus.mem_wb_data, bus.rdata, hit_count, miss_count);
    end
    bus.req = 1'b0;
    #1;
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_stall: got %b want 0", bus.stall);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0002_0004, 32'h0, FUNCT3_SW);
    wait_miss(32'h0000_8001, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 3 || f != 2 || bad != 0 || bus.rdata !== 32'hCAFE_8001) begin
      tests_failed++;
      $display("FAIL refetch_after_reset: got stall=%0d fetch=%0d badaddr=%0d rdata=%h want 3 2 0 cafe8001",
               s, f, bad, bus.rdata);
    end
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0, FUNCT3_SW);
    wait_miss(32'h0000_4000, s, f, w, bad, to, wa, wd);
    if (STATS) begin exp_misses++; exp_hits++; end
    tests_run++;
    if (to || s != 3 || w != 0 || bus.rdata !== 32'h1122_3344) begin
      tests_failed++;
      $display("FAIL invalidated_by_reset: got stall=%0d wb=%0d rdata=%h want 3 0 11223344", s, w, bus.rdata);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, FUNCT3_SW);
  endtask

  task automatic test_stats();
    drive(1'b1, 1'b0, 32'h0002_0004, 32'h0, FUNCT3_SW);
    if (STATS) exp_hits++;
    tests_run++;
    if (bus.stall !== 1'b0 || bus.rdata !== 32'hCAFE_8001) begin
      tests_failed++;
      $display("FAIL stats_hit: got stall=%b rdata=%h want 0 cafe8001", bus.stall, bus.rdata);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, FUNCT3_SW);
    tests_run++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      tests_failed++;
      $display("FAIL stats_counters: got hit=%0d miss=%0d want %0d %0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_hits = 0;
    exp_misses = 0;
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_merge();
    test_dirty_evict();
    test_store_miss();
    test_reset_mid_fetch();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
